// File: rtl/alu_sequencer.sv
// Controller for an external combinational 64-bit ALU: handshaked requests, ALU control
// generation, SLT/SEQ post-processing and a shift-add multiply that reuses the ALU adder.
module alu_sequencer #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned MUL_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zf,
  output logic             out_ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_a_invert,
  output logic             alu_b_invert,
  output logic [1:0]       alu_operation,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out,
  input  logic             alu_zf
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SEQ = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_carry, r_zf, r_ovf;

  logic [WIDTH-1:0] w_res, w_acc_nxt;
  logic             w_carry, w_zf, w_ovf, w_ovf_raw, w_b_msb;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_carry  = r_carry;
  assign out_zf     = r_zf;
  assign out_ovf    = r_ovf;

  // In MUL, r_a holds the shifting multiplicand and r_b the shifting multiplier.
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_a_invert  = 1'b0;
    alu_b_invert  = 1'b0;
    alu_operation = 2'b00;
    alu_carry_in  = 1'b0;
    case (r_state)
      S_EXEC: begin
        alu_a = r_a;
        alu_b = r_b;
        case (r_op)
          OP_AND: alu_operation = 2'b00;
          OP_OR:  alu_operation = 2'b01;
          OP_NOR: begin
            alu_operation = 2'b00;
            alu_a_invert  = 1'b1;
            alu_b_invert  = 1'b1;
          end
          OP_SUB, OP_SLT, OP_SEQ: begin
            alu_operation = 2'b10;
            alu_b_invert  = 1'b1;
            alu_carry_in  = 1'b1;
          end
          default: alu_operation = 2'b10;
        endcase
      end
      S_MUL: begin
        alu_a         = r_acc;
        alu_b         = r_a;
        alu_operation = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = (in_op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: w_state_nxt = S_DONE;
      S_MUL:  if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_b_msb   = alu_b_invert ? ~r_b[WIDTH-1] : r_b[WIDTH-1];
    w_ovf_raw = ~(r_a[WIDTH-1] ^ w_b_msb) & (alu_result[WIDTH-1] ^ r_a[WIDTH-1]);
    w_res     = alu_result;
    w_carry   = alu_carry_out;
    w_zf      = alu_zf;
    w_ovf     = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: w_ovf = w_ovf_raw;
      OP_SLT: begin
        w_res    = '0;
        w_res[0] = alu_result[WIDTH-1] ^ w_ovf_raw;
        w_ovf    = w_ovf_raw;
      end
      OP_SEQ: begin
        w_res    = '0;
        w_res[0] = alu_zf;
      end
      default: w_carry = 1'b0;
    endcase
    w_acc_nxt = r_b[0] ? alu_result : r_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zf     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op  <= in_op;
          r_a   <= in_a;
          r_b   <= in_b;
          r_acc <= '0;
          r_cnt <= '0;
        end
        S_EXEC: begin
          r_result <= w_res;
          r_carry  <= w_carry;
          r_zf     <= w_zf;
          r_ovf    <= w_ovf;
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_result <= w_acc_nxt;
            r_zf     <= (w_acc_nxt == '0);
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, directed requests, queue-based result scoreboard.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        out_carry, out_zf, out_ovf;
  logic [63:0] alu_a, alu_b, alu_result;
  logic        alu_a_invert, alu_b_invert, alu_carry_in, alu_carry_out, alu_zf;
  logic [1:0]  alu_operation;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(64), .MUL_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zf(out_zf), .out_ovf(out_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_a_invert(alu_a_invert), .alu_b_invert(alu_b_invert),
    .alu_operation(alu_operation), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_zf(alu_zf)
  );

  // Reference ALU the sequencer is meant to drive.
  logic [63:0] ae, be;
  logic [64:0] sum;
  always_comb begin
    ae = alu_a_invert ? ~alu_a : alu_a;
    be = alu_b_invert ? ~alu_b : alu_b;
    sum = {1'b0, ae} + {1'b0, be} + {64'd0, alu_carry_in};
    alu_result    = '0;
    alu_carry_out = 1'b0;
    case (alu_operation)
      2'b00: alu_result = ae & be;
      2'b01: alu_result = ae | be;
      2'b10: begin
        alu_result    = sum[63:0];
        alu_carry_out = sum[64];
      end
      default: ;
    endcase
    alu_zf = (alu_result == '0);
  end

  typedef struct {
    string       name;
    logic [63:0] res;
    logic        c, z, o;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result transfers on the edge following a negedge where valid&ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_result: got %0h expected none", out_result);
        end else begin
          e = q.pop_front();
          check(e.name, {61'd0, out_result, out_carry, out_zf, out_ovf},
                {61'd0, e.res, e.c, e.z, e.o});
        end
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] res, input logic c,
                       input logic z, input logic o, input int exp_lat);
    int lat;
    int w;
    exp_t e;
    e.name = name; e.res = res; e.c = c; e.z = z; e.o = o;
    q.push_back(e);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 200);
    check({"lat_", name}, 128'(lat), 128'(exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {60'd0, out_result, out_valid, in_ready, out_carry, out_zf, out_ovf},
          {60'd0, 64'd0, 1'b0, 1'b1, 3'b000});
    reset = 1'b0;

    // Abort a multiply with reset partway through.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b111; in_a = 64'd3; in_b = 64'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("reset_mid_mul", {126'd0, out_valid, in_ready}, {126'd0, 2'b01});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset", {126'd0, out_valid, in_ready}, {126'd0, 2'b01});

    issue("add_1_1",  3'b000, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 1);
    issue("add_wrap", 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 1'b0, 1);
    issue("sub_ovf",  3'b001, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
          1'b1, 1'b0, 1'b1, 1);
    issue("sub_neg",  3'b001, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1);
    issue("slt_min",  3'b101, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 1'b1, 1'b0, 1'b1, 1);
    issue("slt_eq",   3'b101, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1, 1'b0, 1);
    issue("slt_lt",   3'b101, 64'd5, 64'd7, 64'd1, 1'b0, 1'b0, 1'b0, 1);
    issue("and",      3'b010, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1'b0, 1);
    issue("or",       3'b011, 64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0, 1'b0, 1'b0, 1);
    issue("nor",      3'b100, 64'd0, 64'hF0, 64'hFFFF_FFFF_FFFF_FF0F, 1'b0, 1'b0, 1'b0, 1);
    issue("seq_eq",   3'b110, 64'h1234, 64'h1234, 64'd1, 1'b1, 1'b1, 1'b0, 1);
    issue("mul_a",    3'b111, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 1'b0, 1'b0, 1'b0, 64);
    issue("mul_wrap", 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE,
          1'b0, 1'b0, 1'b0, 64);
    issue("mul_zero", 3'b111, 64'hDEAD, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 64);

    // Let the last result transfer before applying backpressure.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue("bp_add", 3'b000, 64'd7, 64'd8, 64'd15, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0); in_op = 3'b000; in_a = 64'd100; in_b = 64'd100;
      check("stall_hold", {62'd0, out_valid, in_ready, out_result}, {62'd0, 2'b10, 64'd15});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("queue_drained", 128'(q.size()), 128'd0);
    check("idle_end", {126'd0, out_valid, in_ready}, {126'd0, 2'b01});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator/controller for the 64-bit ALU.
- Accepts an operation request over a valid/ready handshake, registers the operands, and drives the ALU control inputs (a/b invert, operation, carry-in).
- Captures the ALU result and flags, and returns them over a valid/ready output handshake.
- Adds multi-cycle ops the ALU cannot do alone: SLT/SEQ by subtraction post-processing, and a 64-cycle shift-add MUL (low 64 bits) that reuses the ALU adder every cycle.

Parameters:
- WIDTH, 64, datapath width. Must match the ALU; only 64 is verified.
- MUL_CYCLES, 64, iterations of the shift-add multiply. Must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept a request
- in_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOR, 101 SLT, 110 SEQ, 111 MUL
- in_a  in  64  operand A
- in_b  in  64  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  64  result
- out_carry  out  1  ALU carry_out of the final ALU pass (0 for AND/OR/NOR/MUL)
- out_zf  out  1  zero flag
- out_ovf  out  1  signed overflow (ADD/SUB/SLT only, else 0)
- alu_a  out  64  to ALU a
- alu_b  out  64  to ALU b
- alu_a_invert  out  1  to ALU
- alu_b_invert  out  1  to ALU
- alu_operation  out  2  to ALU; 00 AND, 01 OR, 10 ADD
- alu_carry_in  out  1  to ALU
- alu_result  in  64  from ALU (combinational)
- alu_carry_out  in  1  from ALU
- alu_zf  in  1  from ALU

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, port name reset.
- Reset: state goes to IDLE. out_valid, out_result, out_carry, out_zf, out_ovf and all operand/accumulator registers are 0. in_ready=1 (decoded from IDLE). Reset mid-operation aborts the op; no output is produced.
- FSM states: IDLE, EXEC, MUL, DONE.
  - in_ready = (state==IDLE).
  - IDLE: on in_valid, latch op/a/b. Go to EXEC, or to MUL if op=111 (acc=0, cnt=0, mcand=a, mplier=b).
  - EXEC: one cycle. ALU is driven from the latched regs. On the next edge, capture outputs and go to DONE.
  - MUL: each cycle, alu_a=acc, alu_b=mcand, ADD. If mplier[0], acc<=alu_result. mcand<<=1, mplier>>=1, cnt++. After cnt reaches MUL_CYCLES-1, capture acc (including the final update) and go to DONE.
  - DONE: out_valid=1, outputs held stable. When out_ready is high, go to IDLE and clear out_valid. No new request is accepted in the same cycle.
- Latency and throughput:
  - Non-MUL: out_valid high 1 cycle after the accept edge.
  - MUL: out_valid high MUL_CYCLES cycles after the accept edge.
  - Throughput: at most 1 op per 3 cycles (non-MUL).
- in_valid outside IDLE is ignored; it is not queued.
- ALU control encoding:
  - ADD: op 10, no inversion, cin 0.
  - SUB/SLT/SEQ: op 10, b_invert 1, cin 1.
  - AND: 00.
  - OR: 01.
  - NOR: op 00, a_invert 1, b_invert 1.
  - In IDLE/DONE all ALU drive outputs are 0.
- Overflow: ovf = (a[63] ^ alu_b_eff[63]) == 0 && (alu_result[63] != a[63]), where alu_b_eff = ~b for subtract-class ops.
- Result rules:
  - ADD/SUB/AND/OR/NOR: out_result=alu_result, out_zf=alu_zf.
  - SLT (signed): out_result={63'b0, alu_result[63]^ovf}; out_zf=alu_zf (operands equal); out_carry/out_ovf from the subtract.
  - SEQ: out_result={63'b0, alu_zf}; out_zf=alu_zf.
  - MUL: out_result=low 64 bits of a*b (wraps mod 2^64); out_zf=(result==0); out_carry=0; out_ovf=0.

Test Plan:
- Reset mid-MUL: issue MUL 3*5, assert reset at cycle 10 → out_valid=0, in_ready=1 on release; next ADD 1+1 → 2.
- ADD wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=1 → result 0, zf=1, carry=1, ovf=0, out_valid 1 cycle after accept.
- SUB overflow / SLT: SUB a=64'h8000_0000_0000_0000, b=1 → result 64'h7FFF_FFFF_FFFF_FFFF, ovf=1. SLT same operands → result 1 (signed min < 1). SLT a=5, b=5 → result 0, zf=1.
- NOR/SEQ: NOR a=0, b=64'hF0 → 64'hFFFF_FFFF_FFFF_FF0F. SEQ a=b=64'h1234 → result 1.
- MUL: 64'h1_0000_0001 * 3 → 64'h3_0000_0003 after exactly 64 cycles. MUL 64'hFFFF_FFFF_FFFF_FFFF * 2 → 64'hFFFF_FFFF_FFFF_FFFE. MUL x*0 → 0, zf=1.
- Backpressure: hold out_ready=0 for 10 cycles after ADD 7+8 → out_valid stays 1, result stays 15, in_ready=0. in_valid pulses during the stall are ignored (no second result appears).
